// File: rtl/maxpool_seq_ctrl.sv
// Serialises pairs of per-channel samples into SER_BW slices for a maxpool
// unit, then waits for each pooled result and counts windows per frame.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start, abort    begin a frame (IDLE only) / return to IDLE from any state
//   in_vld, in_rdy  upstream sample handshake; in_data = NO_CH signed samples
//   ser_vld         serial slice valid; ser_data = NO_CH slices, LS slice first
//   mp_vld          maxpool result valid
//   busy            not IDLE
//   win_cnt         windows completed in the current frame
//   frame_done      one-cycle pulse after the last window result
//   err             sticky: mp_vld seen outside WAIT_RES
module maxpool_seq_ctrl #(
  parameter int NO_CH   = 10,
  parameter int BW_IN   = 12,
  parameter int SER_BW  = 4,
  parameter int NUM_WIN = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           in_vld,
  output logic                           in_rdy,
  input  logic [NO_CH-1:0][BW_IN-1:0]    in_data,
  output logic                           ser_vld,
  output logic [NO_CH-1:0][SER_BW-1:0]   ser_data,
  input  logic                           mp_vld,
  output logic                           busy,
  output logic [$clog2(NUM_WIN):0]       win_cnt,
  output logic                           frame_done,
  output logic                           err
);

  localparam int SPW = BW_IN / SER_BW;
  localparam int CW  = $clog2(SPW) + 1;
  localparam int WCW = $clog2(NUM_WIN) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_WAIT
  } state_e;

  state_e                       state_q, state_d;
  logic [NO_CH-1:0][BW_IN-1:0]  sreg_q, sreg_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         pair_q, pair_d;
  logic [WCW-1:0]               win_q, win_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      pair_q  <= 1'b0;
      win_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      pair_q  <= pair_d;
      win_q   <= win_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    pair_d  = pair_q;
    win_d   = win_q;
    done_d  = 1'b0;
    err_d   = err_q;
    if (abort) begin
      // abort freezes counters and err; only the state moves
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            win_d   = '0;
            pair_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
        S_LOAD: begin
          if (in_vld) begin
            state_d = S_SHIFT;
            sreg_d  = in_data;
            cnt_d   = '0;
          end
        end
        S_SHIFT: begin
          for (int i = 0; i < NO_CH; i++) begin
            sreg_d[i] = sreg_q[i] >> SER_BW;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(SPW - 1)) begin
            if (pair_q) begin
              pair_d  = 1'b0;
              state_d = S_WAIT;
            end else begin
              pair_d  = 1'b1;
              state_d = S_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (mp_vld) begin
            win_d = win_q + WCW'(1);
            if (win_q == WCW'(NUM_WIN - 1)) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
      // a stray result always wins over a same-cycle clear
      if (mp_vld && state_q != S_WAIT) begin
        err_d = 1'b1;
      end
    end
  end

  assign in_rdy     = (state_q == S_LOAD);
  assign ser_vld    = (state_q == S_SHIFT);
  assign busy       = (state_q != S_IDLE);
  assign win_cnt    = win_q;
  assign frame_done = done_q;
  assign err        = err_q;

  // slices are only presented while shifting; zero otherwise
  always_comb begin
    ser_data = '0;
    for (int i = 0; i < NO_CH; i++) begin
      ser_data[i] = ser_vld ? sreg_q[i][SER_BW-1:0] : '0;
    end
  end

endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// Directed bench for maxpool_seq_ctrl with NO_CH=2, BW_IN=12, SER_BW=4,
// NUM_WIN=2; expected slices are derived from the driven samples.
module tb_maxpool_seq_ctrl;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic             in_vld;
  logic             in_rdy;
  logic [1:0][11:0] in_data;
  logic             ser_vld;
  logic [1:0][3:0]  ser_data;
  logic             mp_vld;
  logic             busy;
  logic [1:0]       win_cnt;
  logic             frame_done;
  logic             err;

  int n_tests = 0;
  int n_fail  = 0;

  maxpool_seq_ctrl #(
    .NO_CH  (2),
    .BW_IN  (12),
    .SER_BW (4),
    .NUM_WIN(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_data   (in_data),
    .ser_vld   (ser_vld),
    .ser_data  (ser_data),
    .mp_vld    (mp_vld),
    .busy      (busy),
    .win_cnt   (win_cnt),
    .frame_done(frame_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] slice(input logic [23:0] s, input int k);
    return {s[12+4*k +: 4], s[4*k +: 4]};
  endfunction

  // Entered in LOAD; leaves the DUT in WAIT_RES.
  task automatic do_window(input logic [23:0] s0,
                           input logic [23:0] s1,
                           input int gap);
    in_vld = 1'b0;
    for (int g = 0; g < gap; g++) begin
      tick;
      check("bp_rdy", in_rdy, 1);
      check("bp_vld", ser_vld, 0);
    end
    in_vld  = 1'b1;
    in_data = s0;
    tick;
    in_data = s1;
    for (int k = 0; k < 3; k++) begin
      check("s0_vld", ser_vld, 1);
      check("s0_dat", ser_data, slice(s0, k));
      tick;
    end
    check("gap_vld", ser_vld, 0);
    check("gap_rdy", in_rdy, 1);
    tick;
    in_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("s1_vld", ser_vld, 1);
      check("s1_dat", ser_data, slice(s1, k));
      tick;
    end
    check("wait_vld", ser_vld, 0);
    check("wait_rdy", in_rdy, 0);
    check("wait_busy", busy, 1);
  endtask

  task automatic ret_result;
    repeat (2) tick;
    check("wait_hold", ser_vld, 0);
    mp_vld = 1'b1;
    tick;
    mp_vld = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  localparam logic [23:0] SA = {12'h321, 12'hABC};
  localparam logic [23:0] SB = {12'h654, 12'hDEF};
  localparam logic [23:0] SC = {12'h987, 12'h0F5};
  localparam logic [23:0] SD = {12'h1E2, 12'h7A4};

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    in_vld  = 1'b0;
    in_data = '0;
    mp_vld  = 1'b0;
    #3;
    check("rst_rdy", in_rdy, 0);
    check("rst_vld", ser_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_win", win_cnt, 0);
    check("rst_err", err, 0);
    repeat (2) tick;
    rst = 1'b1;
    tick;
    in_vld = 1'b1;
    repeat (3) tick;
    check("nostart_busy", busy, 0);
    check("nostart_rdy", in_rdy, 0);
    in_vld = 1'b0;

    // serialization order and full frame with backpressure
    do_start;
    check("ld_rdy", in_rdy, 1);
    check("ld_busy", busy, 1);
    check("ld_win", win_cnt, 0);
    do_window(SA, SB, 0);
    ret_result;
    check("w1_cnt", win_cnt, 1);
    check("w1_rdy", in_rdy, 1);
    check("w1_done", frame_done, 0);
    start = 1'b1;
    do_window(SC, SD, 5);
    start = 1'b0;
    check("busy_start_win", win_cnt, 1);
    ret_result;
    check("fr_done", frame_done, 1);
    check("fr_win", win_cnt, 2);
    check("fr_busy", busy, 0);
    tick;
    check("fr_pulse", frame_done, 0);
    check("fr_hold", win_cnt, 2);

    // abort after beat 2 of sample 1 in the second window
    do_start;
    check("ab_clr", win_cnt, 0);
    do_window(SB, SA, 0);
    ret_result;
    in_vld  = 1'b1;
    in_data = SC;
    tick;
    in_data = SD;
    repeat (4) tick;
    check("ab_b1", ser_data, slice(SD, 0));
    tick;
    check("ab_b2", ser_data, slice(SD, 1));
    abort = 1'b1;
    tick;
    abort = 1'b0;
    in_vld = 1'b0;
    check("ab_vld", ser_vld, 0);
    check("ab_busy", busy, 0);
    check("ab_rdy", in_rdy, 0);
    check("ab_win", win_cnt, 1);
    check("ab_done", frame_done, 0);
    tick;
    check("ab_vld2", ser_vld, 0);
    check("ab_done2", frame_done, 0);

    // stray result in LOAD
    do_start;
    check("er_init", err, 0);
    mp_vld = 1'b1;
    tick;
    mp_vld = 1'b0;
    check("er_set", err, 1);
    repeat (3) tick;
    check("er_hold", err, 1);
    check("er_ld", in_rdy, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("er_abort", err, 1);
    do_start;
    check("er_clr", err, 0);

    // async reset in WAIT_RES
    do_window(SA, SC, 0);
    ret_result;
    do_window(SD, SB, 0);
    check("ar_pre", win_cnt, 1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_rdy", in_rdy, 0);
    check("ar_vld", ser_vld, 0);
    check("ar_dat", ser_data, 0);
    check("ar_busy", busy, 0);
    check("ar_win", win_cnt, 0);
    check("ar_done", frame_done, 0);
    check("ar_err", err, 0);
    rst = 1'b1;
    repeat (2) tick;
    check("ar_idle", busy, 0);
    check("ar_novld", ser_vld, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
